// File: rtl/log_fifo_reader.sv
// Read-side controller for the frame-detector log FIFO.
// Pops one entry at a time and streams it out LSB-first as AXIS beats.
module log_fifo_reader #(
    parameter int C_ENTRY_WIDTH = 202,
    parameter int C_AXIS_WIDTH  = 32,
    parameter int C_COUNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic                     fifo_valid,
    input  logic [C_ENTRY_WIDTH-1:0] fifo_dout,
    output logic [C_AXIS_WIDTH-1:0]  m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     busy,
    output logic [C_COUNT_WIDTH-1:0] entries_sent
);

    localparam int BEATS =
        (C_ENTRY_WIDTH + C_AXIS_WIDTH - 1) / C_AXIS_WIDTH;
    localparam int SW = BEATS * C_AXIS_WIDTH;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [SW-1:0]            r_shift;
    logic [BW-1:0]            r_beat;
    logic [C_COUNT_WIDTH-1:0] r_sent;
    logic                     w_last;
    logic                     w_hs;

    assign w_last = (r_beat == BW'(BEATS - 1));
    assign w_hs   = (r_state == S_SEND) && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (fifo_valid) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_hs && w_last) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Final beat is zero-padded by the zero-extended load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_beat  <= '0;
            r_sent  <= '0;
        end else begin
            if (r_state == S_WAIT && fifo_valid) begin
                r_shift <= SW'(fifo_dout);
                r_beat  <= '0;
            end else if (w_hs) begin
                if (w_last) begin
                    r_sent <= r_sent + C_COUNT_WIDTH'(1);
                end else begin
                    r_shift <= r_shift >> C_AXIS_WIDTH;
                    r_beat  <= r_beat + BW'(1);
                end
            end
        end
    end

    always_comb begin
        fifo_rd_en    = (r_state == S_READ);
        m_axis_tvalid = (r_state == S_SEND);
        m_axis_tlast  = (r_state == S_SEND) && w_last;
        m_axis_tdata  = '0;
        if (r_state == S_SEND) begin
            m_axis_tdata = r_shift[C_AXIS_WIDTH-1:0];
        end
        busy          = (r_state != S_IDLE);
        entries_sent  = r_sent;
    end

endmodule

// File: tb/tb_log_fifo_reader.sv
// Bench for log_fifo_reader: FIFO model with read latency 1,
// beat scoreboard, stall stability monitor.
module tb_log_fifo_reader;

    localparam int EW    = 202;
    localparam int AW    = 32;
    localparam int CW    = 4;
    localparam int BEATS = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          fifo_valid = 1'b0;
    logic [EW-1:0] fifo_dout = '0;
    logic [AW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          busy;
    logic [CW-1:0] entries_sent;

    log_fifo_reader #(
        .C_ENTRY_WIDTH(EW),
        .C_AXIS_WIDTH (AW),
        .C_COUNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_valid   (fifo_valid),
        .fifo_dout    (fifo_dout),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .entries_sent (entries_sent)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            fcount = 0;
    int            exp_sent = 0;
    logic [EW-1:0] fq[$];
    logic [AW:0]   sb[$];
    logic [AW:0]   ex;
    bit            rnd = 1'b0;

    int   rd_cnt = 0;
    int   last_cnt = 0;
    int   beat_cnt = 0;
    int   rd_first = -1;
    int   tv_first = -1;
    int   mon_beat = 0;
    logic prev_stall = 1'b0;
    logic [AW-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    assign fifo_empty = (fcount == 0);

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
    end

    // FIFO model, standard mode, read latency 1
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            n_checks++;
            if (fq.size() == 0) begin
                n_fail++;
                $display("FAIL over_read: rd_en=1 with fifo count 0");
                fifo_valid <= 1'b0;
            end else begin
                fifo_dout  <= fq.pop_front();
                fifo_valid <= 1'b1;
                fcount     <= fcount - 1;
            end
        end else begin
            fifo_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en && rd_first < 0) rd_first = cyc;
        if (m_axis_tvalid && tv_first < 0) tv_first = cyc;
        if (fifo_rd_en) begin
            rd_cnt++;
            n_checks++;
            if (m_axis_tvalid) begin
                n_fail++;
                $display("FAIL rd_in_send: rd_en=1 tvalid=1 want tvalid=0");
            end
        end
        if (fifo_valid && (!busy || m_axis_tvalid || fifo_rd_en)) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_outside_wait: busy=%0b tvalid=%0b rd_en=%0b",
                     busy, m_axis_tvalid, fifo_rd_en);
        end
        if (prev_stall) begin
            n_checks++;
            if (!m_axis_tvalid || m_axis_tdata !== prev_data ||
                m_axis_tlast !== prev_last) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                         m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                         prev_data, prev_last);
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL extra_beat: got d=%h l=%0b want no beat",
                         m_axis_tdata, m_axis_tlast);
            end else begin
                ex = sb.pop_front();
                if ({m_axis_tlast, m_axis_tdata} !== ex) begin
                    n_fail++;
                    $display("FAIL beat%0d: got l=%0b d=%h want l=%0b d=%h",
                             mon_beat, m_axis_tlast, m_axis_tdata,
                             ex[AW], ex[AW-1:0]);
                end
            end
            beat_cnt++;
            if (m_axis_tlast) begin
                last_cnt++;
                mon_beat = 0;
            end else begin
                mon_beat++;
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
    end

    task automatic push_entry(input logic [EW-1:0] e);
        logic [BEATS*AW-1:0] t;
        logic                lst;
        t = '0;
        t[EW-1:0] = e;
        fq.push_back(e);
        fcount = fcount + 1;
        for (int k = 0; k < BEATS; k++) begin
            lst = (k == BEATS - 1);
            sb.push_back({lst, t[k*AW +: AW]});
        end
    endtask

    function automatic logic [EW-1:0] rand_entry();
        logic [BEATS*AW-1:0] t;
        for (int w = 0; w < BEATS; w++) t[w*AW +: AW] = $urandom;
        return t[EW-1:0];
    endfunction

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(!busy && fcount == 0 && sb.size() == 0 && !fifo_valid)
                   && n < budget);
        if (n >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy=%0b fifo=%0d sb=%0d after %0d cycles",
                     name, busy, fcount, sb.size(), n);
        end
    endtask

    task automatic wait_beat(input int idx, input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(m_axis_tvalid && mon_beat == idx) && n < budget);
        if (n >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: beat %0d never presented", name, idx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, fifo_rd_en, busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got v/l/rd/busy=%b want 0000",
                     {m_axis_tvalid, m_axis_tlast, fifo_rd_en, busy});
        end
        n_checks++;
        if (m_axis_tdata !== '0 || entries_sent !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got d=%h cnt=%0d want 0 0",
                     m_axis_tdata, entries_sent);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single();
        logic [EW-1:0] e;
        int k, r0, l0;
        for (int i = 0; i < EW; i++) e[i] = i[0];
        enable = 1'b1;
        m_axis_tready = 1'b1;
        r0 = rd_cnt;
        l0 = last_cnt;
        @(posedge clk);
        #1;
        rd_first = -1;
        tv_first = -1;
        push_entry(e);
        k = cyc;
        wait_done(100, "single");
        exp_sent++;
        n_checks++;
        if (rd_first != k + 1) begin
            n_fail++;
            $display("FAIL single_rd_lat: got cycle %0d want %0d", rd_first, k + 1);
        end
        n_checks++;
        if (tv_first != k + 3) begin
            n_fail++;
            $display("FAIL single_tv_lat: got cycle %0d want %0d", tv_first, k + 3);
        end
        n_checks++;
        if (rd_cnt - r0 != 1 || last_cnt - l0 != 1) begin
            n_fail++;
            $display("FAIL single_counts: got rd=%0d last=%0d want 1 1",
                     rd_cnt - r0, last_cnt - l0);
        end
        n_checks++;
        if (entries_sent !== CW'(exp_sent) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_sent: got cnt=%0d busy=%0b want %0d 0",
                     entries_sent, busy, CW'(exp_sent));
        end
    endtask

    task automatic test_stall();
        int b0;
        b0 = beat_cnt;
        @(posedge clk);
        #1;
        rnd = 1'b1;
        push_entry(rand_entry());
        wait_done(400, "stall");
        rnd = 1'b0;
        m_axis_tready = 1'b1;
        exp_sent++;
        n_checks++;
        if (beat_cnt - b0 != BEATS || entries_sent !== CW'(exp_sent)) begin
            n_fail++;
            $display("FAIL stall_total: got beats=%0d cnt=%0d want %0d %0d",
                     beat_cnt - b0, entries_sent, BEATS, CW'(exp_sent));
        end
    endtask

    task automatic test_back_to_back();
        int r0, l0, b0;
        r0 = rd_cnt;
        l0 = last_cnt;
        b0 = beat_cnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push_entry(rand_entry());
        wait_done(300, "b2b");
        exp_sent += 3;
        n_checks++;
        if (rd_cnt - r0 != 3 || last_cnt - l0 != 3 || beat_cnt - b0 != 21) begin
            n_fail++;
            $display("FAIL b2b_counts: got rd=%0d last=%0d beats=%0d want 3 3 21",
                     rd_cnt - r0, last_cnt - l0, beat_cnt - b0);
        end
        n_checks++;
        if (entries_sent !== CW'(exp_sent)) begin
            n_fail++;
            $display("FAIL b2b_sent: got %0d want %0d", entries_sent, CW'(exp_sent));
        end
    endtask

    task automatic test_enable_drop();
        int r0, l0, n;
        r0 = rd_cnt;
        l0 = last_cnt;
        @(posedge clk);
        #1;
        push_entry(rand_entry());
        push_entry(rand_entry());
        wait_beat(3, 100, "drop");
        #1;
        enable = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        repeat (20) @(negedge clk);
        n_checks++;
        if (rd_cnt - r0 != 1 || last_cnt - l0 != 1 || fcount != 1) begin
            n_fail++;
            $display("FAIL drop_stop: got rd=%0d last=%0d fifo=%0d want 1 1 1",
                     rd_cnt - r0, last_cnt - l0, fcount);
        end
        n_checks++;
        if (busy !== 1'b0 || entries_sent !== CW'(exp_sent + 1)) begin
            n_fail++;
            $display("FAIL drop_idle: got busy=%0b cnt=%0d want 0 %0d",
                     busy, entries_sent, CW'(exp_sent + 1));
        end
        enable = 1'b1;
        wait_done(200, "drop_resume");
        exp_sent += 2;
        n_checks++;
        if (rd_cnt - r0 != 2 || entries_sent !== CW'(exp_sent)) begin
            n_fail++;
            $display("FAIL drop_resume: got rd=%0d cnt=%0d want 2 %0d",
                     rd_cnt - r0, entries_sent, CW'(exp_sent));
        end
    endtask

    task automatic test_reset_mid();
        int l0;
        @(posedge clk);
        #1;
        push_entry(rand_entry());
        push_entry(rand_entry());
        wait_beat(4, 100, "rstmid");
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, fifo_rd_en, busy} !== 4'b0 ||
            m_axis_tdata !== '0 || entries_sent !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got v/l/rd/busy=%b d=%h cnt=%0d want 0",
                     {m_axis_tvalid, m_axis_tlast, fifo_rd_en, busy},
                     m_axis_tdata, entries_sent);
        end
        for (int i = 0; i < BEATS - 4; i++) void'(sb.pop_front());
        mon_beat = 0;
        exp_sent = 0;
        l0 = last_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_done(200, "rstmid");
        exp_sent++;
        n_checks++;
        if (last_cnt - l0 != 1 || entries_sent !== CW'(exp_sent)) begin
            n_fail++;
            $display("FAIL rstmid_next: got last=%0d cnt=%0d want 1 %0d",
                     last_cnt - l0, entries_sent, CW'(exp_sent));
        end
    endtask

    task automatic test_wrap();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_sent = 0;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            push_entry(rand_entry());
            wait_done(100, "wrap");
            exp_sent++;
            n_checks++;
            if (entries_sent !== CW'(exp_sent)) begin
                n_fail++;
                $display("FAIL wrap_%0d: got %0d want %0d",
                         i + 1, entries_sent, CW'(exp_sent));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
